// File: rtl/cyclic_light_monitor_if.sv
// rtl/cyclic_light_monitor_if.sv - light bus plus monitor status bundle
interface cyclic_light_monitor_if #(
    parameter int CNT_W = 8
);
    logic [2:0]       light;
    logic [1:0]       phase;
    logic             locked;
    logic             err_pulse;
    logic             err_onehot;
    logic             err_seq;
    logic             err_dwell;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] cyc_count;

    modport master (
        output light,
        input  phase, locked, err_pulse, err_onehot, err_seq, err_dwell,
        input  err_count, cyc_count
    );

    modport slave (
        input  light,
        output phase, locked, err_pulse, err_onehot, err_seq, err_dwell,
        output err_count, cyc_count
    );
endinterface

// File: rtl/cyclic_light_monitor.sv
// rtl/cyclic_light_monitor.sv - RGY light bus checker: one-hot, order and dwell
module cyclic_light_monitor #(
    parameter int R_CYCLES = 1,
    parameter int G_CYCLES = 1,
    parameter int Y_CYCLES = 1,
    parameter int CNT_W    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    cyclic_light_monitor_if.slave  bus
);
    localparam logic [1:0] SYNC   = 2'd0;
    localparam logic [1:0] RED    = 2'd1;
    localparam logic [1:0] GREEN  = 2'd2;
    localparam logic [1:0] YELLOW = 2'd3;

    logic [1:0]       st, st_n, sp, nxt;
    logic [CNT_W-1:0] dwell, dwell_n, lim;
    logic             onehot;
    logic             e_oh, e_seq, e_dw, cyc_inc;
    logic             pulse_q, oh_q, seq_q, dw_q;
    logic [CNT_W-1:0] err_cnt_q, cyc_cnt_q;

    // State encoding doubles as the decoded phase value.
    always_comb begin
        onehot = 1'b0;
        sp     = SYNC;
        case (bus.light)
            3'b100:  begin onehot = 1'b1; sp = RED;    end
            3'b010:  begin onehot = 1'b1; sp = GREEN;  end
            3'b001:  begin onehot = 1'b1; sp = YELLOW; end
            default: begin onehot = 1'b0; sp = SYNC;   end
        endcase
    end

    always_comb begin
        case (st)
            RED:     begin lim = CNT_W'(R_CYCLES); nxt = GREEN;  end
            GREEN:   begin lim = CNT_W'(G_CYCLES); nxt = YELLOW; end
            YELLOW:  begin lim = CNT_W'(Y_CYCLES); nxt = RED;    end
            default: begin lim = '0;               nxt = SYNC;   end
        endcase
    end

    always_comb begin
        st_n    = st;
        dwell_n = dwell;
        e_oh    = 1'b0;
        e_seq   = 1'b0;
        e_dw    = 1'b0;
        cyc_inc = 1'b0;
        if (st == SYNC) begin
            if (onehot) begin
                st_n    = sp;
                dwell_n = CNT_W'(1);
            end
        end else if (!onehot) begin
            st_n    = SYNC;
            dwell_n = '0;
            e_oh    = 1'b1;
        end else if (sp == st) begin
            if (dwell != '1) dwell_n = dwell + CNT_W'(1);
            // Equality only on the crossing sample, so a long dwell flags once.
            e_dw = (dwell == lim);
        end else if (sp == nxt) begin
            e_dw    = (dwell < lim);
            st_n    = sp;
            dwell_n = CNT_W'(1);
            cyc_inc = (st == YELLOW);
        end else begin
            e_seq   = 1'b1;
            st_n    = sp;
            dwell_n = CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= SYNC;
            dwell     <= '0;
            pulse_q   <= 1'b0;
            oh_q      <= 1'b0;
            seq_q     <= 1'b0;
            dw_q      <= 1'b0;
            err_cnt_q <= '0;
            cyc_cnt_q <= '0;
        end else begin
            st      <= st_n;
            dwell   <= dwell_n;
            pulse_q <= e_oh | e_seq | e_dw;
            if (e_oh)  oh_q  <= 1'b1;
            if (e_seq) seq_q <= 1'b1;
            if (e_dw)  dw_q  <= 1'b1;
            if ((e_oh | e_seq | e_dw) && (err_cnt_q != '1))
                err_cnt_q <= err_cnt_q + CNT_W'(1);
            if (cyc_inc)
                cyc_cnt_q <= cyc_cnt_q + CNT_W'(1);
        end
    end

    assign bus.phase      = st;
    assign bus.locked     = (st != SYNC);
    assign bus.err_pulse  = pulse_q;
    assign bus.err_onehot = oh_q;
    assign bus.err_seq    = seq_q;
    assign bus.err_dwell  = dw_q;
    assign bus.err_count  = err_cnt_q;
    assign bus.cyc_count  = cyc_cnt_q;
endmodule

// File: tb/tb_cyclic_light_monitor.sv
// tb/tb_cyclic_light_monitor.sv - directed checks on three monitor configurations
module tb_cyclic_light_monitor;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] G = 3'b010;
    localparam logic [2:0] Y = 3'b001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cyclic_light_monitor_if #(.CNT_W(8)) ifa ();
    cyclic_light_monitor_if #(.CNT_W(8)) ifb ();
    cyclic_light_monitor_if #(.CNT_W(8)) ifc ();

    cyclic_light_monitor #(.R_CYCLES(1), .G_CYCLES(1), .Y_CYCLES(1), .CNT_W(8))
        dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    cyclic_light_monitor #(.R_CYCLES(3), .G_CYCLES(2), .Y_CYCLES(1), .CNT_W(8))
        dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
    cyclic_light_monitor #(.R_CYCLES(2), .G_CYCLES(1), .Y_CYCLES(1), .CNT_W(8))
        dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [2:0] v);
        ifa.light = v;
        ifb.light = v;
        ifc.light = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ifa.light = 3'b000;
        ifb.light = 3'b000;
        ifc.light = 3'b000;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        ifa.light = 3'b000;
        ifb.light = 3'b000;
        ifc.light = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_phase",  32'(ifa.phase), 0);
        chk("rst_locked", 32'(ifa.locked), 0);
        chk("rst_errcnt", 32'(ifa.err_count), 0);
        chk("rst_cyc",    32'(ifa.cyc_count), 0);
        rst = 1'b0;

        // Defaults: R,G,Y x4
        step(R);
        chk("t1_locked", 32'(ifa.locked), 1);
        chk("t1_phR",    32'(ifa.phase), 1);
        step(G);
        chk("t1_phG",    32'(ifa.phase), 2);
        step(Y);
        chk("t1_phY",    32'(ifa.phase), 3);
        for (int i = 0; i < 3; i++) begin
            step(R); step(G); step(Y);
        end
        chk("t1_cyc",    32'(ifa.cyc_count), 3);
        chk("t1_errcnt", 32'(ifa.err_count), 0);
        chk("t1_errs",   32'({ifa.err_onehot, ifa.err_seq, ifa.err_dwell}), 0);

        // R=3,G=2,Y=1: exact dwell sequence
        do_reset();
        for (int i = 0; i < 2; i++) begin
            step(R); step(R); step(R); step(G); step(G); step(Y);
        end
        step(R);
        chk("t2_cyc",    32'(ifb.cyc_count), 2);
        chk("t2_errcnt", 32'(ifb.err_count), 0);
        chk("t2_dwell",  32'(ifb.err_dwell), 0);
        do_reset();
        step(R); step(R);
        step(G);
        chk("t2_short_pulse", 32'(ifb.err_pulse), 1);
        step(G); step(Y);
        chk("t2_short_dwell", 32'(ifb.err_dwell), 1);
        chk("t2_short_cnt",   32'(ifb.err_count), 1);

        // R=2: too-long flagged once
        do_reset();
        step(R); step(R);
        chk("t3_pulse2", 32'(ifc.err_pulse), 0);
        step(R);
        chk("t3_pulse3", 32'(ifc.err_pulse), 1);
        step(R);
        chk("t3_pulse4", 32'(ifc.err_pulse), 0);
        step(G);
        chk("t3_pulseG", 32'(ifc.err_pulse), 0);
        chk("t3_cnt",    32'(ifc.err_count), 1);
        chk("t3_dwell",  32'(ifc.err_dwell), 1);

        // Sequence errors
        do_reset();
        step(R); step(Y);
        chk("t4_seq",   32'(ifa.err_seq), 1);
        chk("t4_phase", 32'(ifa.phase), 3);
        chk("t4_cnt1",  32'(ifa.err_count), 1);
        step(G);
        chk("t4_pulse", 32'(ifa.err_pulse), 1);
        chk("t4_cnt2",  32'(ifa.err_count), 2);

        // Non-one-hot
        do_reset();
        step(R); step(G); step(3'b110);
        chk("t5_onehot", 32'(ifa.err_onehot), 1);
        chk("t5_unlock", 32'(ifa.locked), 0);
        chk("t5_ph0",    32'(ifa.phase), 0);
        step(G);
        chk("t5_phG",    32'(ifa.phase), 2);
        chk("t5_relock", 32'(ifa.locked), 1);
        chk("t5_cnt",    32'(ifa.err_count), 1);
        do_reset();
        step(3'b000); step(3'b000); step(3'b000);
        chk("t5_zero_lock", 32'(ifa.locked), 0);
        chk("t5_zero_cnt",  32'(ifa.err_count), 0);
        chk("t5_zero_pul",  32'(ifa.err_pulse), 0);

        // Asynchronous reset mid-GREEN with flags set
        do_reset();
        step(R); step(Y); step(R); step(G);
        chk("t6_pre_seq", 32'(ifa.err_seq), 1);
        chk("t6_pre_cyc", 32'(ifa.cyc_count), 1);
        rst = 1'b1;
        #1;
        chk("t6_phase",  32'(ifa.phase), 0);
        chk("t6_locked", 32'(ifa.locked), 0);
        chk("t6_seq",    32'(ifa.err_seq), 0);
        chk("t6_cnt",    32'(ifa.err_count), 0);
        chk("t6_cyc",    32'(ifa.cyc_count), 0);
        rst = 1'b0;
        step(G);
        chk("t6_resync_ph",  32'(ifa.phase), 2);
        chk("t6_resync_pul", 32'(ifa.err_pulse), 0);

        // Saturation: reversed order gives one error per sample after the first
        do_reset();
        for (int i = 0; i < 100; i++) begin
            step(R); step(Y); step(G);
        end
        chk("t6_sat_cnt", 32'(ifa.err_count), 255);
        chk("t6_sat_seq", 32'(ifa.err_seq), 1);
        chk("t6_sat_cyc", 32'(ifa.cyc_count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
